// File: rtl/line_buffer_window_gen_if.sv
// Bus bundle for line_buffer_window_gen.
// Groups three sets of signals:
//   - the raster pixel input (in_valid / in_sof / in_data),
//   - the two line-buffer SRAM ports (I = row r-1, II = row r-2),
//   - the 3x3 window output (win_valid / win_data / win_last / frame_done).
// Modports:
//   master : the window generator.
//   slave  : its environment (pixel source, SRAMs, window consumer).
interface line_buffer_window_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;

  logic [ADDR_W-1:0] lb_rd_addr_I, lb_rd_addr_II;
  logic [DATA_W-1:0] lb_rd_data_I, lb_rd_data_II;
  logic [ADDR_W-1:0] lb_wr_addr_I, lb_wr_addr_II;
  logic [DATA_W-1:0] lb_wr_data_I, lb_wr_data_II;
  logic              lb_wr_en_I, lb_wr_en_II;

  logic                win_valid;
  logic [9*DATA_W-1:0] win_data;
  logic                win_last;
  logic                frame_done;

  modport master (
    input  in_valid, in_sof, in_data, lb_rd_data_I, lb_rd_data_II,
    output lb_rd_addr_I, lb_rd_addr_II, lb_wr_addr_I, lb_wr_addr_II,
           lb_wr_data_I, lb_wr_data_II, lb_wr_en_I, lb_wr_en_II,
           win_valid, win_data, win_last, frame_done
  );

  modport slave (
    output in_valid, in_sof, in_data, lb_rd_data_I, lb_rd_data_II,
    input  lb_rd_addr_I, lb_rd_addr_II, lb_wr_addr_I, lb_wr_addr_II,
           lb_wr_data_I, lb_wr_data_II, lb_wr_en_I, lb_wr_en_II,
           win_valid, win_data, win_last, frame_done
  );
endinterface

// File: rtl/line_buffer_window_gen.sv
// Line-buffer feeder and 3x3 sliding-window generator for one line-buffer group.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset.
//   bus        : pixel input, line-buffer I/II SRAM ports, window output.
// Pipeline:
//   stage 0 : position the pixel (sof resyncs to (0,0)), read both buffers at col c.
//   stage 1 : write pixel -> LB I and LB I data -> LB II at col c, shift the window.
//   output  : window registered; valid only for r>=2 and c>=2.
module line_buffer_window_gen #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ROW_W  = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  line_buffer_window_gen_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_R = ROW_W'(IMG_H - 1);

  logic [ADDR_W-1:0] col_q, pos_c, s1_c;
  logic [ROW_W-1:0]  row_q, pos_r, s1_r;
  logic [DATA_W-1:0] s1_pix;
  logic              s1_valid, sof_hit, at_last;
  logic              win_valid_q, win_last_q, frame_done_q;
  logic [8:0][DATA_W-1:0] win_q;

  // in_sof only counts together with in_valid; it forces this pixel to (0,0).
  assign sof_hit = bus.in_valid & bus.in_sof;
  assign pos_c   = sof_hit ? '0 : col_q;
  assign pos_r   = sof_hit ? '0 : row_q;
  assign at_last = (pos_r == LAST_R) && (pos_c == LAST_C);

  // Stage 0: both buffers read at the current column; data returns in stage 1.
  assign bus.lb_rd_addr_I  = pos_c;
  assign bus.lb_rd_addr_II = pos_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (bus.in_valid) begin
      if (pos_c == LAST_C) begin
        col_q <= '0;
        row_q <= (pos_r == LAST_R) ? '0 : pos_r + 1'b1;
      end else begin
        col_q <= pos_c + 1'b1;
        row_q <= pos_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_pix       <= '0;
      s1_c         <= '0;
      s1_r         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s1_valid     <= bus.in_valid;
      frame_done_q <= bus.in_valid & at_last;
      if (bus.in_valid) begin
        s1_pix <= bus.in_data;
        s1_c   <= pos_c;
        s1_r   <= pos_r;
      end
    end
  end

  // Stage 1: column c is written here while stage 0 already reads c+1 (or 0),
  // so a read and a write never hit the same address in one cycle.
  assign bus.lb_wr_en_I    = s1_valid;
  assign bus.lb_wr_en_II   = s1_valid;
  assign bus.lb_wr_addr_I  = s1_c;
  assign bus.lb_wr_addr_II = s1_c;
  assign bus.lb_wr_data_I  = s1_pix;
  assign bus.lb_wr_data_II = bus.lb_rd_data_I;

  // Window: row i occupies elements 3i..3i+2, column 2 is newest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      win_valid_q <= s1_valid && (s1_r >= ROW_W'(2)) && (s1_c >= ADDR_W'(2));
      win_last_q  <= s1_valid && (s1_r == LAST_R) && (s1_c == LAST_C);
      if (s1_valid) begin
        for (int i = 0; i < 3; i++) begin
          win_q[3*i]   <= win_q[3*i+1];
          win_q[3*i+1] <= win_q[3*i+2];
        end
        win_q[2] <= bus.lb_rd_data_II;
        win_q[5] <= bus.lb_rd_data_I;
        win_q[8] <= s1_pix;
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_line_buffer_window_gen.sv
module tb_line_buffer_window_gen;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int ROW_W  = 5;
  localparam int NPIX   = IMG_W * IMG_H;

  typedef struct packed {
    logic [8:0][DATA_W-1:0] e;
    logic                   last;
  } win_t;

  typedef struct packed {
    logic [ADDR_W-1:0] c;
    logic [DATA_W-1:0] pix;
    logic              has_ii;
    logic [DATA_W-1:0] ii;
    logic              last;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  line_buffer_window_gen_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  line_buffer_window_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ROW_W(ROW_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: synchronous write, 1-cycle registered read.
  logic [DATA_W-1:0] mem_I  [2**ADDR_W];
  logic [DATA_W-1:0] mem_II [2**ADDR_W];
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem_I[i]  = '0;
      mem_II[i] = '0;
    end
    bus.lb_rd_data_I  = '0;
    bus.lb_rd_data_II = '0;
  end
  always @(posedge clk) begin
    if (bus.lb_wr_en_I)  mem_I[bus.lb_wr_addr_I]   <= bus.lb_wr_data_I;
    if (bus.lb_wr_en_II) mem_II[bus.lb_wr_addr_II] <= bus.lb_wr_data_II;
    bus.lb_rd_data_I  <= mem_I[bus.lb_rd_addr_I];
    bus.lb_rd_data_II <= mem_II[bus.lb_rd_addr_II];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard queues and reference model state
  win_t wq_win[$];
  wr_t  wq_wr[$];
  int   img[IMG_H][IMG_W];
  int   mr = 0, mc = 0, t22 = 0, exp_rd = 0;

  // Epoch statistics collected by the monitor
  int win_cnt = 0, first_cyc = -1, last_e8 = -1, min_e = 65535;
  logic [8:0][DATA_W-1:0] first_win = '0;
  int p_cnt = 0, p_last = -1, p_f0 = -1, p_f8 = -1;

  task automatic mark();
    p_cnt = win_cnt; p_last = last_e8; p_f0 = first_win[0]; p_f8 = first_win[8];
    win_cnt = 0; first_cyc = -1; last_e8 = -1; min_e = 65535;
  endtask

  task automatic send(input bit v, input bit sof, input int val);
    int r, c;
    win_t w;
    wr_t  wr;
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = DATA_W'(val);
    if (v) begin
      r = sof ? 0 : mr;
      c = sof ? 0 : mc;
      exp_rd = c;
      img[r][c] = val;
      wr.c = ADDR_W'(c); wr.pix = DATA_W'(val);
      wr.has_ii = (r >= 1); wr.ii = '0;
      if (r >= 1) wr.ii = DATA_W'(img[r-1][c]);
      wr.last = (r == IMG_H-1) && (c == IMG_W-1);
      wq_wr.push_back(wr);
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w.e[3*i+j] = DATA_W'(img[r-2+i][c-2+j]);
        w.last = wr.last;
        wq_win.push_back(w);
        if (r == 2 && c == 2) t22 = cyc;
      end
      if (c == IMG_W-1) begin
        mc = 0;
        mr = (r == IMG_H-1) ? 0 : r + 1;
      end else begin
        mc = c + 1;
        mr = r;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(0, 0, 0);
  endtask

  // Pixels k in [k0,k1) of a raster frame, value base + r*32 + c.
  task automatic run_frame(input int base, input bit bub, input int k0, input int k1, input bit sof0);
    for (int k = k0; k < k1; k++) begin
      int r, c;
      r = k / IMG_W;
      c = k % IMG_W;
      if (k == IMG_W) mark();
      if (bub) while ($urandom_range(0, 1) == 1) send(0, 1'($urandom_range(0, 1)), 12345);
      send(1, sof0 && (k == 0), base + r*32 + c);
    end
  endtask

  // Reset with in_valid toggling; the pixel accepted just before reset
  // still writes the buffers but its window is discarded.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_sof = 1'b0; bus.in_data = 16'd777;
    @(posedge clk); #1;
    wq_win.delete(); wq_wr.delete();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_sof = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    mr = 0; mc = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a window or a write.
  bit prev_acc = 1'b0;
  always @(negedge clk) begin
    win_t w;
    wr_t  wr;
    if (bus.win_valid) begin
      if (wq_win.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        w = wq_win.pop_front();
        for (int k = 0; k < 9; k++)
          chk($sformatf("win_e%0d", k), bus.win_data[k*DATA_W +: DATA_W], w.e[k]);
        chk("win_last", bus.win_last, w.last);
      end
      if (win_cnt == 0) begin
        first_win = bus.win_data;
        first_cyc = cyc;
      end
      win_cnt++;
      if (bus.win_last) last_e8 = bus.win_data[8*DATA_W +: DATA_W];
      for (int k = 0; k < 9; k++)
        if (int'(bus.win_data[k*DATA_W +: DATA_W]) < min_e) min_e = bus.win_data[k*DATA_W +: DATA_W];
    end else begin
      chk("win_last_idle", bus.win_last, 0);
    end
    if (prev_acc) begin
      if (wq_wr.size() == 0) begin
        chk("wr_queue_empty", 1, 0);
      end else begin
        wr = wq_wr.pop_front();
        chk("wr_en", {bus.lb_wr_en_I, bus.lb_wr_en_II}, 3);
        chk("wr_addr_I", bus.lb_wr_addr_I, wr.c);
        chk("wr_addr_II", bus.lb_wr_addr_II, wr.c);
        chk("wr_data_I", bus.lb_wr_data_I, wr.pix);
        if (wr.has_ii) chk("wr_data_II", bus.lb_wr_data_II, wr.ii);
        chk("frame_done", bus.frame_done, wr.last);
      end
    end else begin
      chk("wr_idle", {bus.lb_wr_en_I, bus.lb_wr_en_II, bus.frame_done}, 0);
    end
    if (bus.in_valid && rst_n) begin
      chk("rd_addr_I", bus.lb_rd_addr_I, exp_rd);
      chk("rd_addr_II", bus.lb_rd_addr_II, exp_rd);
    end
    prev_acc = bus.in_valid && rst_n;
  end

  int exp_first[9] = '{0, 1, 2, 32, 33, 34, 64, 65, 66};

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    do_reset();
    @(negedge clk);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_win_data", |bus.win_data, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_rd_addr", bus.lb_rd_addr_I, 0);

    // Frame 1: continuous, sof on (0,0) is a no-op
    run_frame(0, 0, 0, NPIX, 1);
    idle(4);
    chk("f1_count", win_cnt, 676);
    for (int k = 0; k < 9; k++) chk($sformatf("f1_first_e%0d", k), first_win[k], exp_first[k]);
    chk("f1_last_e8", last_e8, 891);
    chk("f1_latency", first_cyc - t22, 2);

    // Same frame with bubbles, then a back-to-back second frame
    run_frame(0, 1, 0, NPIX, 0);
    run_frame(1000, 0, 0, NPIX, 0);
    chk("bub_count", p_cnt, 676);
    chk("bub_first_e0", p_f0, 0);
    chk("bub_first_e8", p_f8, 66);
    chk("bub_last_e8", p_last, 891);
    idle(4);
    chk("f2_count", win_cnt, 676);
    chk("f2_first_e0", first_win[0], 1000);
    chk("f2_first_e8", first_win[8], 1066);
    chk("f2_min_elem_ge_1000", min_e >= 1000, 1);
    chk("f2_last_e8", last_e8, 1891);

    // Reset at row 10, then a fresh frame
    run_frame(0, 0, 0, 10*IMG_W + 5, 0);
    do_reset();
    run_frame(5000, 0, 0, NPIX, 0);
    idle(4);
    chk("rst_f_count", win_cnt, 676);
    chk("rst_f_first_e0", first_win[0], 5000);
    chk("rst_f_first_e8", first_win[8], 5066);
    chk("rst_f_latency", first_cyc - t22, 2);

    // Resync: sof at (5,7) restarts the frame
    run_frame(0, 0, 0, 5*IMG_W + 7, 0);
    send(1, 1, 3000);
    run_frame(3000, 0, 1, NPIX, 0);
    idle(4);
    chk("sof_count", win_cnt, 676);
    chk("sof_first_e0", first_win[0], 3000);
    chk("sof_first_e8", first_win[8], 3066);
    chk("sof_latency", first_cyc - t22, 2);
    chk("sof_last_e8", last_e8, 3891);

    chk("win_queue_drained", wq_win.size(), 0);
    chk("wr_queue_drained", wq_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
